// File: rtl/way_halt_pkg.sv
// rtl/way_halt_pkg.sv - shared parameters, flush FSM states and width helpers
package way_halt_pkg;

  localparam int NUM_WAYS_DEF = 8;
  localparam int NUM_SETS_DEF = 16;
  localparam int HALT_W_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } flush_state_e;

  // Index widths never collapse to zero so single-entry builds still elaborate
  function automatic int calc_way_w(input int num_ways);
    return (num_ways <= 1) ? 1 : $clog2(num_ways);
  endfunction

  function automatic int calc_set_w(input int num_sets);
    return (num_sets <= 1) ? 1 : $clog2(num_sets);
  endfunction

endpackage

// File: rtl/way_halt_match.sv
// rtl/way_halt_match.sv - per-way halt tag compare for one selected set row
module way_halt_match
  import way_halt_pkg::*;
#(
  parameter int NUM_WAYS = NUM_WAYS_DEF,
  parameter int HALT_W   = HALT_W_DEF
) (
  input  logic [NUM_WAYS-1:0][HALT_W-1:0] i_row_tag,
  input  logic [NUM_WAYS-1:0]             i_row_valid,
  input  logic [HALT_W-1:0]               i_lk_tag,
  output logic [NUM_WAYS-1:0]             o_enable
);

  always_comb begin
    o_enable = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      o_enable[w] = i_row_valid[w] && (i_row_tag[w] == i_lk_tag);
    end
  end

endmodule

// File: rtl/way_halt_ctrl.sv
// rtl/way_halt_ctrl.sv - way-halting controller: halt tag array, lookup mask, sequenced flush
module way_halt_ctrl
  import way_halt_pkg::*;
#(
  parameter int NUM_WAYS = NUM_WAYS_DEF,
  parameter int NUM_SETS = NUM_SETS_DEF,
  parameter int HALT_W   = HALT_W_DEF,
  localparam int WAY_W   = calc_way_w(NUM_WAYS),
  localparam int SET_W   = calc_set_w(NUM_SETS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lk_valid,
  output logic                lk_ready,
  input  logic [SET_W-1:0]    lk_set,
  input  logic [HALT_W-1:0]   lk_tag,
  output logic                rsp_valid,
  output logic [NUM_WAYS-1:0] rsp_enable,
  output logic                rsp_none,
  input  logic                fill_en,
  input  logic [SET_W-1:0]    fill_set,
  input  logic [WAY_W-1:0]    fill_way,
  input  logic [HALT_W-1:0]   fill_tag,
  input  logic                inv_en,
  input  logic [SET_W-1:0]    inv_set,
  input  logic [WAY_W-1:0]    inv_way,
  input  logic                flush_start,
  output logic                flush_busy,
  output logic                flush_done
);

  flush_state_e r_state;
  flush_state_e w_state_nxt;
  logic [SET_W-1:0] r_cnt;
  logic [SET_W-1:0] w_cnt_nxt;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0]             r_valid;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][HALT_W-1:0] r_tag;

  logic                w_idle;
  logic                w_accept;
  logic                w_fill;
  logic                w_inv;
  logic [NUM_WAYS-1:0] w_mask;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = lk_valid && w_idle;
  // Maintenance traffic during a flush is dropped, never queued
  assign w_fill   = fill_en && w_idle;
  assign w_inv    = inv_en && w_idle;

  assign lk_ready   = w_idle;
  assign flush_busy = !w_idle;
  assign flush_done = (r_state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (flush_start) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = '0;
        end
      end
      ST_FLUSH: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == SET_W'(NUM_SETS - 1)) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Invalidate has priority over fill on the same entry; the tag is still written
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SETS; s++) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (!reset) begin
          r_valid[s][w] <= 1'b0;
        end else if ((r_state == ST_FLUSH) && (r_cnt == SET_W'(s))) begin
          r_valid[s][w] <= 1'b0;
        end else if (w_inv && (inv_set == SET_W'(s)) && (inv_way == WAY_W'(w))) begin
          r_valid[s][w] <= 1'b0;
        end else if (w_fill && (fill_set == SET_W'(s)) && (fill_way == WAY_W'(w))) begin
          r_valid[s][w] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[fill_set][fill_way] <= fill_tag;
    end
  end

  way_halt_match #(
    .NUM_WAYS (NUM_WAYS),
    .HALT_W   (HALT_W)
  ) u_match (
    .i_row_tag   (r_tag[lk_set]),
    .i_row_valid (r_valid[lk_set]),
    .i_lk_tag    (lk_tag),
    .o_enable    (w_mask)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid  <= 1'b0;
      rsp_enable <= '0;
      rsp_none   <= 1'b0;
    end else begin
      rsp_valid <= w_accept;
      if (w_accept) begin
        rsp_enable <= w_mask;
        rsp_none   <= ~|w_mask;
      end
    end
  end

endmodule

// File: tb/tb_way_halt_ctrl.sv
// tb/tb_way_halt_ctrl.sv - directed table-driven bench for way_halt_ctrl
module tb_way_halt_ctrl;
  import way_halt_pkg::*;

  localparam int NW = 8;
  localparam int NS = 16;
  localparam int HW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          lk_valid;
  logic          lk_ready;
  logic [3:0]    lk_set;
  logic [HW-1:0] lk_tag;
  logic          rsp_valid;
  logic [NW-1:0] rsp_enable;
  logic          rsp_none;
  logic          fill_en;
  logic [3:0]    fill_set;
  logic [2:0]    fill_way;
  logic [HW-1:0] fill_tag;
  logic          inv_en;
  logic [3:0]    inv_set;
  logic [2:0]    inv_way;
  logic          flush_start;
  logic          flush_busy;
  logic          flush_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  way_halt_ctrl #(.NUM_WAYS(NW), .NUM_SETS(NS), .HALT_W(HW)) dut (
    .clk         (clk),
    .reset       (reset),
    .lk_valid    (lk_valid),
    .lk_ready    (lk_ready),
    .lk_set      (lk_set),
    .lk_tag      (lk_tag),
    .rsp_valid   (rsp_valid),
    .rsp_enable  (rsp_enable),
    .rsp_none    (rsp_none),
    .fill_en     (fill_en),
    .fill_set    (fill_set),
    .fill_way    (fill_way),
    .fill_tag    (fill_tag),
    .inv_en      (inv_en),
    .inv_set     (inv_set),
    .inv_way     (inv_way),
    .flush_start (flush_start),
    .flush_busy  (flush_busy),
    .flush_done  (flush_done)
  );

  typedef struct {
    logic       fe;
    logic [3:0] fs;
    logic [2:0] fw;
    logic [3:0] ft;
    logic       ie;
    logic [3:0] is;
    logic [2:0] iw;
    logic       lv;
    logic [3:0] ls;
    logic [3:0] lt;
    logic [7:0] exp_en;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    lk_valid = 0; lk_set = 0; lk_tag = 0;
    fill_en = 0; fill_set = 0; fill_way = 0; fill_tag = 0;
    inv_en = 0; inv_set = 0; inv_way = 0;
    flush_start = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill(input int s, input int w, input int t);
    fill_en = 1; fill_set = 4'(s); fill_way = 3'(w); fill_tag = 4'(t);
    step();
    fill_en = 0;
  endtask

  task automatic do_lookup(input string name, input int s, input int t, input int exp);
    lk_valid = 1; lk_set = 4'(s); lk_tag = 4'(t);
    step();
    lk_valid = 0;
    chk({name, "_valid"}, int'(rsp_valid), 1);
    chk({name, "_en"}, int'(rsp_enable), exp);
    chk({name, "_none"}, int'(rsp_none), int'(exp == 0));
  endtask

  initial begin
    int low_cnt;
    int done_cnt;
    int guard;

    //            fe fs fw ft   ie is iw  lv ls lt   exp
    vecs[0]  = '{0, 0, 0, 0,   0, 0, 0,  1, 3, 5,   8'h00};
    vecs[1]  = '{1, 3, 2, 5,   0, 0, 0,  0, 0, 0,   8'h00};
    vecs[2]  = '{1, 3, 6, 5,   0, 0, 0,  0, 0, 0,   8'h00};
    vecs[3]  = '{0, 0, 0, 0,   0, 0, 0,  1, 3, 5,   8'h44};
    vecs[4]  = '{0, 0, 0, 0,   0, 0, 0,  1, 3, 6,   8'h00};
    vecs[5]  = '{0, 0, 0, 0,   0, 0, 0,  1, 4, 5,   8'h00};
    vecs[6]  = '{1, 1, 0, 10,  0, 0, 0,  1, 1, 10,  8'h00};
    vecs[7]  = '{0, 0, 0, 0,   0, 0, 0,  1, 1, 10,  8'h01};
    vecs[8]  = '{1, 2, 7, 3,   1, 2, 7,  0, 0, 0,   8'h00};
    vecs[9]  = '{0, 0, 0, 0,   0, 0, 0,  1, 2, 3,   8'h00};
    vecs[10] = '{1, 2, 7, 3,   0, 0, 0,  0, 0, 0,   8'h00};
    vecs[11] = '{0, 0, 0, 0,   0, 0, 0,  1, 2, 3,   8'h80};
    vecs[12] = '{1, 5, 1, 9,   1, 3, 2,  1, 3, 5,   8'h44};
    vecs[13] = '{0, 0, 0, 0,   0, 0, 0,  1, 3, 5,   8'h40};
    vecs[14] = '{0, 0, 0, 0,   0, 0, 0,  1, 5, 9,   8'h02};
    vecs[15] = '{0, 0, 0, 0,   1, 2, 7,  1, 2, 3,   8'h80};
    vecs[16] = '{0, 0, 0, 0,   0, 0, 0,  1, 2, 3,   8'h00};

    idle_inputs();
    reset = 0;
    step();
    step();
    reset = 1;
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_enable", int'(rsp_enable), 0);
    chk("rst_rsp_none", int'(rsp_none), 0);
    chk("rst_flush_busy", int'(flush_busy), 0);
    chk("rst_flush_done", int'(flush_done), 0);
    chk("rst_lk_ready", int'(lk_ready), 1);

    for (int i = 0; i < 17; i++) begin
      fill_en = vecs[i].fe; fill_set = vecs[i].fs; fill_way = vecs[i].fw; fill_tag = vecs[i].ft;
      inv_en = vecs[i].ie; inv_set = vecs[i].is; inv_way = vecs[i].iw;
      lk_valid = vecs[i].lv; lk_set = vecs[i].ls; lk_tag = vecs[i].lt;
      step();
      chk($sformatf("vec%0d_valid", i), int'(rsp_valid), int'(vecs[i].lv));
      if (vecs[i].lv) begin
        chk($sformatf("vec%0d_en", i), int'(rsp_enable), int'(vecs[i].exp_en));
        chk($sformatf("vec%0d_none", i), int'(rsp_none), int'(vecs[i].exp_en == 0));
      end
    end
    idle_inputs();

    // Flush with a lookup accepted on the same edge
    do_fill(0, 3, 15);
    do_fill(15, 7, 1);
    lk_valid = 1; lk_set = 3; lk_tag = 5; flush_start = 1;
    step();
    idle_inputs();
    chk("flush_lk_valid", int'(rsp_valid), 1);
    chk("flush_lk_en", int'(rsp_enable), 8'h40);
    chk("flush_busy_start", int'(flush_busy), 1);
    low_cnt = 0; done_cnt = 0; guard = 0;
    while (!lk_ready && guard < 40) begin
      low_cnt++;
      if (flush_done) done_cnt++;
      chk("flush_busy_hi", int'(flush_busy), 1);
      if (low_cnt == 3) begin
        fill_en = 1; fill_set = 7; fill_way = 0; fill_tag = 2;
      end else begin
        fill_en = 0;
      end
      step();
      guard++;
    end
    fill_en = 0;
    chk("flush_ready_low_cycles", low_cnt, NS + 1);
    chk("flush_done_pulses", done_cnt, 1);
    chk("flush_idle_busy", int'(flush_busy), 0);
    do_lookup("pf_s0", 0, 15, 0);
    do_lookup("pf_s1", 1, 10, 0);
    do_lookup("pf_s3", 3, 5, 0);
    do_lookup("pf_s5", 5, 9, 0);
    do_lookup("pf_s15", 15, 1, 0);
    do_lookup("pf_dropped_fill", 7, 2, 0);

    // Reset in the middle of a flush
    do_fill(3, 6, 5);
    do_fill(12, 4, 12);
    flush_start = 1;
    step();
    flush_start = 0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_flush_busy", int'(flush_busy), 1);
    reset = 0;
    step();
    reset = 1;
    chk("abort_busy", int'(flush_busy), 0);
    chk("abort_done", int'(flush_done), 0);
    chk("abort_ready", int'(lk_ready), 1);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (flush_done) done_cnt++;
      step();
    end
    chk("abort_no_done", done_cnt, 0);
    do_lookup("ab_s3", 3, 5, 0);
    do_lookup("ab_s12", 12, 12, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/way_halt_ctrl.md
# way_halt_ctrl

Parametrised way-halting controller for the set-associative cache. Holds a NUM_SETS x NUM_WAYS array of HALT_W-bit halt tags, each with a valid bit. Each lookup returns a registered per-way enable mask: only ways whose valid halt tag matches the low tag bits are enabled for the full tag/data access. Adds per-set indexing, valid bits, invalidate, a handshaked lookup and a sequenced flush.

## Interface
- NUM_WAYS, 8, associativity (power of two, 2..16)
- NUM_SETS, 16, sets tracked (power of two, >=2)
- HALT_W, 4, halt tag width
- WAY_W / SET_W, derived: clog2(NUM_WAYS) / clog2(NUM_SETS)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- lk_valid  in  1  lookup request
- lk_ready  out  1  lookup can be accepted
- lk_set  in  SET_W  lookup set index
- lk_tag  in  HALT_W  low tag bits of the access
- rsp_valid  out  1  response valid (one-cycle pulse)
- rsp_enable  out  NUM_WAYS  way enable mask (bit i = way i valid and matching)
- rsp_none  out  1  all ways halted (rsp_enable == 0)
- fill_en  in  1  write halt tag and set valid
- fill_set / fill_way / fill_tag  in  SET_W / WAY_W / HALT_W  fill target and value
- inv_en  in  1  clear valid of one entry
- inv_set / inv_way  in  SET_W / WAY_W  invalidate target
- flush_start  in  1  start whole-array flush
- flush_busy  out  1  flush in progress
- flush_done  out  1  one-cycle pulse at flush completion

## Operation
- Lookup is accepted when lk_valid && lk_ready. The mask is computed from the set's current, pre-edge contents: enable[i] = valid[set][i] && (tag[set][i] == lk_tag).
- Fill writes tag and sets valid. Invalidate clears valid only; the tag is retained.
- Fill and invalidate to the same entry in the same cycle: invalidate wins, so valid = 0 and the tag takes fill_tag.
- Fill and invalidate to different entries in the same cycle: both apply.
- A lookup in the same cycle as a fill or invalidate to its set sees the old contents. The update is visible to lookups accepted on the next cycle.
- Flush FSM has three states:
  - IDLE: flush_start → FLUSH, with set counter = 0.
  - FLUSH: clears all valid bits of set[counter]; counter increments; at counter == NUM_SETS-1 → DONE.
  - DONE: flush_done = 1 → IDLE.
- Flush scope and side effects:
  - Flush clears valid bits only; tags are untouched.
  - flush_start is ignored outside IDLE.
  - In FLUSH and DONE: lk_ready = 0, and fill_en / inv_en are ignored (dropped, not queued).
- flush_start in the same cycle as an accepted lookup: the lookup completes normally; the flush starts on the same edge.
- Reset (reset == 0 at an edge):
  - all valid bits cleared; FSM to IDLE; counter 0; rsp_valid, rsp_enable, rsp_none, flush_busy, flush_done = 0.
  - Tags need not be reset.
  - Reset mid-flush aborts it with no flush_done pulse.

## Timing
- Lookup latency is 1 cycle: accept at edge N, rsp_* valid in cycle N+1.
- rsp_enable and rsp_none hold their value until the next accepted lookup. rsp_valid is high for one cycle per accept.
- lk_ready = (state == IDLE), combinational from state, with no dependence on lk_valid. Back-to-back lookups sustain 1 per cycle.
- Flush takes NUM_SETS cycles in FLUSH plus 1 cycle in DONE.
- flush_busy is high in FLUSH and DONE.
- flush_done is high in DONE.
- First lookup after a flush is accepted the cycle after DONE.
- Post-reset: lk_ready = 1 in the first cycle with reset high.

## Structure
- Shared package way_halt_pkg holds:
  - default parameters NUM_WAYS, NUM_SETS, HALT_W
  - flush FSM state typedef (IDLE, FLUSH, DONE)
  - helper constant functions for WAY_W / SET_W
- One sub-module, way_halt_match: one set row's NUM_WAYS tags and valid bits plus lk_tag in, NUM_WAYS-bit enable mask out. Purely combinational, instantiated once on the selected row.
- Storage: a flop array for valid bits (flush clears a whole row per cycle) and a plain register array for tags.

## Test plan
- Reset, then lookup set 3, tag 0x5 → rsp_valid 1 cycle later, rsp_enable = 0x00, rsp_none = 1.
- Fill set 3 way 2 tag 0x5 and set 3 way 6 tag 0x5, then lookup set 3 tag 0x5 → rsp_enable = 0x44. Lookup set 3 tag 0x6 → 0x00. Lookup set 4 tag 0x5 → 0x00.
- Same-cycle lookup and fill: lookup set 1 tag 0xA with fill set 1 way 0 tag 0xA → response 0x00. Lookup next cycle → 0x01.
- Fill and invalidate set 2 way 7 in the same cycle (fill tag 0x3), then lookup set 2 tag 0x3 → rsp_enable = 0x00.
- Fill several sets, then pulse flush_start:
  - lk_ready is low for exactly NUM_SETS+1 = 17 cycles
  - flush_done pulses once
  - a fill issued mid-flush is dropped
  - every later lookup → 0x00
- Start a flush, assert reset at cycle 5 of FLUSH → no flush_done, flush_busy = 0, lk_ready = 1 after release, all lookups → 0x00.
